// File: rtl/keccak_sponge.sv
// Keccak sponge controller: absorbs rate-sized blocks, sequences an external
// combinational round function one round per clock, and squeezes XOF blocks.

module keccak_sponge_lane #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             zero,
    input  logic             perm,
    input  logic             absorb,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] rin,
    output logic [WIDTH-1:0] q
);
    // zero (clr / end of squeeze) outranks the round load and the absorb XOR
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       q <= '0;
        else if (zero)   q <= '0;
        else if (perm)   q <= rin;
        else if (absorb) q <= q ^ din;
    end
endmodule

module keccak_sponge #(
    parameter int WIDTH      = 64,
    parameter int RATE_LANES = 17,
    parameter int NROUNDS    = 24
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          clr,
    input  logic [RATE_LANES*WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [7:0]                    sq_blocks,
    output logic                          in_ready,
    output logic [RATE_LANES*WIDTH-1:0]   out_data,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [25*WIDTH-1:0]           rnd_state_o,
    output logic [4:0]                    rnd_idx_o,
    input  logic [25*WIDTH-1:0]           rnd_state_i
);
    typedef enum logic [1:0] {ABSORB, PERM, SQUEEZE} fsm_e;

    localparam logic [4:0] RC_LAST = 5'(NROUNDS - 1);

    fsm_e                    fsm;
    logic [4:0]              rc;
    logic                    phase;
    logic [7:0]              sq_left;
    logic [24:0][WIDTH-1:0]  st;
    logic [24:0][WIDTH-1:0]  st_rin;
    logic                    lane_zero, lane_perm, lane_absorb;

    assign st_rin      = rnd_state_i;
    assign rnd_state_o = st;
    assign rnd_idx_o   = rc;
    assign out_data    = st[RATE_LANES-1:0];

    // in_ready mirrors fsm==ABSORB, so it doubles as the state decode here
    assign lane_absorb = in_ready && in_valid && !clr;
    assign lane_perm   = (fsm == PERM) && !clr;
    assign lane_zero   = clr || ((fsm == SQUEEZE) && out_ready && (sq_left <= 8'd1));

    for (genvar k = 0; k < 25; k++) begin : g_lane
        logic [WIDTH-1:0] din;
        if (k < RATE_LANES) begin : g_rate
            assign din = in_data[k*WIDTH +: WIDTH];
        end else begin : g_cap
            assign din = '0;
        end
        keccak_sponge_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .nrst   (nrst),
            .zero   (lane_zero),
            .perm   (lane_perm),
            .absorb (lane_absorb),
            .din    (din),
            .rin    (st_rin[k]),
            .q      (st[k])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm       <= ABSORB;
            rc        <= '0;
            phase     <= 1'b0;
            sq_left   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            fsm       <= ABSORB;
            rc        <= '0;
            phase     <= 1'b0;
            sq_left   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                ABSORB: begin
                    if (in_valid) begin
                        fsm      <= PERM;
                        rc       <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_last) begin
                            phase   <= 1'b1;
                            sq_left <= (sq_blocks == 8'd0) ? 8'd1 : sq_blocks;
                        end
                    end
                end
                PERM: begin
                    if (rc == RC_LAST) begin
                        rc   <= '0;
                        busy <= 1'b0;
                        if (phase) begin
                            fsm       <= SQUEEZE;
                            out_valid <= 1'b1;
                            out_last  <= (sq_left == 8'd1);
                        end else begin
                            fsm      <= ABSORB;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        rc <= rc + 5'd1;
                    end
                end
                SQUEEZE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (sq_left <= 8'd1) begin
                            fsm      <= ABSORB;
                            phase    <= 1'b0;
                            sq_left  <= '0;
                            in_ready <= 1'b1;
                        end else begin
                            fsm     <= PERM;
                            sq_left <= sq_left - 8'd1;
                            busy    <= 1'b1;
                        end
                    end
                end
                default: begin
                    fsm      <= ABSORB;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
